vram_arbiter: RTL and testbench

Arbitrates the single-port nametable VRAM between the PPU background/sprite fetch engine and the CPU PPUDATA ($2007) access path. The block sits between those two requesters and the VRAM block. It drives VRAM's address, write-data and read/write enables, and routes the 1-cycle-latency read data back to the requester that issued the read. The PPU has priority. A starvation counter guarantees the CPU a slot during continuous rendering.

---
 rtl/nes_ppu_pkg.sv | 14 +
 rtl/vram_arbiter.sv | 155 +++++++++++++++
 tb/tb_vram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_ppu_pkg.sv
// rtl/nes_ppu_pkg.sv - shared types and default widths for the PPU VRAM path
package nes_ppu_pkg;

    // Which requester receives the VRAM read data returning next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PPU  = 2'd1,
        OWN_CPU  = 2'd2
    } rd_owner_e;

    localparam int VRAM_ADDR_W = 12;
    localparam int VRAM_DATA_W = 8;

endpackage

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - PPU/CPU arbiter for the single-port nametable VRAM
module vram_arbiter
    import nes_ppu_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_gnt,
    output logic              ppu_rvalid,
    output logic [DATA_W-1:0] ppu_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_overrun,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    output logic              vram_wren,
    output logic              vram_rden,
    input  logic [DATA_W-1:0] vram_rdata
);

    // The wait counter only ever needs to reach STARVE_LIMIT (at most 255)
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    // CPU holding register
    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [7:0]        wait_cnt_q, wait_cnt_d;
    rd_owner_e         rd_owner_q, rd_owner_d;

    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_W-1:0] vram_wdata_q, vram_wdata_d;

    logic              cpu_win;
    logic              cpu_rd_issue;
    logic              cpu_wr_issue;

    // Grant: the PPU wins unless the held CPU access has waited its full budget
    always_comb begin
        cpu_win      = valid_q & (~ppu_req | (wait_cnt_q == LIMIT));
        ppu_gnt      = ppu_req & ~cpu_win;
        cpu_rd_issue = cpu_win & ~we_q;
        cpu_wr_issue = cpu_win & we_q;
    end

    // Next-state for holding register, starvation counter, read owner and CPU status
    always_comb begin
        valid_d      = valid_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        rd_owner_d   = OWN_NONE;
        done_d       = 1'b0;
        overrun_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;

        // A request only lands in an empty register; the grant cycle still counts as busy
        if (cpu_win) begin
            valid_d = 1'b0;
        end
        if (cpu_req && !valid_q) begin
            valid_d = 1'b1;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
        end
        overrun_d = cpu_req & valid_q;

        if (!valid_q || cpu_win) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        if (ppu_gnt) begin
            rd_owner_d  = OWN_PPU;
            vram_addr_d = ppu_addr;
        end else if (cpu_win) begin
            rd_owner_d  = cpu_rd_issue ? OWN_CPU : OWN_NONE;
            vram_addr_d = addr_q;
        end

        if (cpu_wr_issue) begin
            vram_wdata_d = wdata_q;
        end

        // Writes complete the cycle after issue, reads the cycle after data returns
        if (rd_owner_q == OWN_CPU) begin
            cpu_rdata_d = vram_rdata;
        end
        done_d = cpu_wr_issue | (rd_owner_q == OWN_CPU);
    end

    // State registers; reset discards any read still in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_cnt_q   <= 8'd0;
            rd_owner_q   <= OWN_NONE;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
        end else begin
            valid_q      <= valid_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            rd_owner_q   <= rd_owner_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
        end
    end

    // Output decode; address/data are live in the issue cycle and held otherwise
    always_comb begin
        vram_addr   = vram_addr_d;
        vram_wdata  = vram_wdata_d;
        vram_rden   = ppu_gnt | cpu_rd_issue;
        vram_wren   = cpu_wr_issue;
        ppu_rvalid  = (rd_owner_q == OWN_PPU);
        ppu_rdata   = ppu_rvalid ? vram_rdata : '0;
        cpu_busy    = valid_q;
        cpu_done    = done_q;
        cpu_rdata   = cpu_rdata_q;
        cpu_overrun = overrun_q;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ppu_req;
    logic [11:0] ppu_addr;
    logic        ppu_gnt;
    logic        ppu_rvalid;
    logic [7:0]  ppu_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic [7:0]  cpu_rdata;
    logic        cpu_overrun;
    logic [11:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_wren;
    logic        vram_rden;
    logic [7:0]  vram_rdata;
    logic        preload;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .ppu_req     (ppu_req),
        .ppu_addr    (ppu_addr),
        .ppu_gnt     (ppu_gnt),
        .ppu_rvalid  (ppu_rvalid),
        .ppu_rdata   (ppu_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_busy    (cpu_busy),
        .cpu_done    (cpu_done),
        .cpu_rdata   (cpu_rdata),
        .cpu_overrun (cpu_overrun),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_wren   (vram_wren),
        .vram_rden   (vram_rden),
        .vram_rdata  (vram_rdata)
    );

    function automatic logic [7:0] pat(input int a);
        int t;
        t = a * 7 + 3;
        return t[7:0];
    endfunction

    // VRAM model: single port, one-cycle read latency
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else begin
            if (vram_wren) mem[vram_addr] <= vram_wdata;
            if (vram_rden) vram_rdata <= mem[vram_addr];
        end
    end

    typedef struct {
        logic        ppu_req;
        logic [11:0] ppu_addr;
        logic        cpu_req;
        logic        cpu_we;
        logic [11:0] cpu_addr;
        logic [7:0]  cpu_wdata;
        logic        e_gnt;
        logic        e_wren;
        logic        e_rden;
        logic [11:0] e_addr;
        logic [7:0]  e_wdata;
        logic        e_busy;
        logic        e_done;
        logic        e_ovr;
        logic [7:0]  e_rdata;
    } vec_t;

    typedef struct {
        logic       we;
        logic [7:0] data;
    } cpu_exp_t;

    vec_t       vecs [13];
    logic [7:0] shadow [4096];
    logic [7:0] ppu_q [$];
    cpu_exp_t   cpu_q [$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_ppu_rv = 0;
    int         n_cpu_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: runs once per cycle at the falling edge
    task automatic monitor();
        cpu_exp_t e;
        if (!reset) begin
            check("rden_wren_exclusive", {63'd0, vram_rden & vram_wren}, 64'd0);
            if (ppu_rvalid) begin
                n_ppu_rv++;
                if (ppu_q.size() == 0) check("ppu_rvalid_unexpected", 64'd1, 64'd0);
                else check("ppu_rdata", {56'd0, ppu_rdata}, {56'd0, ppu_q.pop_front()});
            end
            if (ppu_gnt) ppu_q.push_back(shadow[ppu_addr]);
            if (cpu_done) begin
                n_cpu_done++;
                if (cpu_q.size() == 0) check("cpu_done_unexpected", 64'd1, 64'd0);
                else begin
                    e = cpu_q.pop_front();
                    if (!e.we) check("cpu_rdata", {56'd0, cpu_rdata}, {56'd0, e.data});
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic preq, input logic [11:0] paddr, input logic creq,
                         input logic cwe, input logic [11:0] caddr, input logic [7:0] cwd);
        ppu_req   = preq;
        ppu_addr  = paddr;
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwd;
    endtask

    task automatic push_cpu(input logic we, input logic [11:0] a, input logic [7:0] d);
        cpu_exp_t e;
        e.we = we;
        if (we) begin
            shadow[a] = d;
            e.data = d;
        end else begin
            e.data = shadow[a];
        end
        cpu_q.push_back(e);
    endtask

    function automatic logic [63:0] all_outputs();
        return {21'd0, ppu_gnt, ppu_rvalid, ppu_rdata, cpu_busy, cpu_done, cpu_rdata,
                cpu_overrun, vram_addr, vram_wdata, vram_wren, vram_rden};
    endfunction

    initial begin
        int ppu_cnt;
        int rv0;
        int dn0;

        //          preq paddr  creq we  caddr   wdata  gnt wr rd eaddr   ewd    bsy dn ov  rdata
        vecs[0]  = '{0, 12'h000, 1, 1, 12'h2A5, 8'h3C, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 8'h00};
        vecs[1]  = '{0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 1, 0, 12'h2A5, 8'h3C, 1, 0, 0, 8'h00};
        vecs[2]  = '{0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h2A5, 8'h3C, 0, 1, 0, 8'h00};
        vecs[3]  = '{0, 12'h000, 1, 0, 12'h2A5, 8'h00, 0, 0, 0, 12'h2A5, 8'h3C, 0, 0, 0, 8'h00};
        vecs[4]  = '{0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 1, 12'h2A5, 8'h3C, 1, 0, 0, 8'h00};
        vecs[5]  = '{0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h2A5, 8'h3C, 0, 0, 0, 8'h00};
        vecs[6]  = '{0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h2A5, 8'h3C, 0, 1, 0, 8'h3C};
        vecs[7]  = '{0, 12'h000, 1, 1, 12'h100, 8'h55, 0, 0, 0, 12'h2A5, 8'h3C, 0, 0, 0, 8'h3C};
        vecs[8]  = '{0, 12'h000, 1, 1, 12'h101, 8'hAA, 0, 1, 0, 12'h100, 8'h55, 1, 0, 0, 8'h3C};
        vecs[9]  = '{0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h100, 8'h55, 0, 1, 1, 8'h3C};
        vecs[10] = '{0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h100, 8'h55, 0, 0, 0, 8'h3C};
        vecs[11] = '{1, 12'h005, 0, 0, 12'h000, 8'h00, 1, 0, 1, 12'h005, 8'h55, 0, 0, 0, 8'h3C};
        vecs[12] = '{0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h005, 8'h55, 0, 0, 0, 8'h3C};

        for (int i = 0; i < 4096; i++) shadow[i] = pat(i);

        // Reset and VRAM preload
        reset   = 1'b1;
        preload = 1'b1;
        drive(0, 12'h000, 0, 0, 12'h000, 8'h00);
        #1;
        check("reset_outputs", all_outputs(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        check("reset_outputs_held", all_outputs(), 64'd0);
        reset = 1'b0;

        // Table-driven cycle vectors: write, read-back, overrun, single PPU read
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].ppu_req, vecs[i].ppu_addr, vecs[i].cpu_req, vecs[i].cpu_we,
                  vecs[i].cpu_addr, vecs[i].cpu_wdata);
            if (vecs[i].cpu_req && !vecs[i].e_busy)
                push_cpu(vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata);
            sample();
            check($sformatf("v%0d_ppu_gnt", i), {63'd0, ppu_gnt}, {63'd0, vecs[i].e_gnt});
            check($sformatf("v%0d_wren", i), {63'd0, vram_wren}, {63'd0, vecs[i].e_wren});
            check($sformatf("v%0d_rden", i), {63'd0, vram_rden}, {63'd0, vecs[i].e_rden});
            check($sformatf("v%0d_vram_addr", i), {52'd0, vram_addr}, {52'd0, vecs[i].e_addr});
            check($sformatf("v%0d_vram_wdata", i), {56'd0, vram_wdata}, {56'd0, vecs[i].e_wdata});
            check($sformatf("v%0d_busy", i), {63'd0, cpu_busy}, {63'd0, vecs[i].e_busy});
            check($sformatf("v%0d_done", i), {63'd0, cpu_done}, {63'd0, vecs[i].e_done});
            check($sformatf("v%0d_overrun", i), {63'd0, cpu_overrun}, {63'd0, vecs[i].e_ovr});
            check($sformatf("v%0d_cpu_rdata", i), {56'd0, cpu_rdata}, {56'd0, vecs[i].e_rdata});
            advance();
        end
        check("mem_written_first", {56'd0, mem[12'h100]}, 64'h55);
        check("mem_dropped_untouched", {56'd0, mem[12'h101]}, {56'd0, pat(12'h101)});

        // PPU streaming 0x000..0x00F
        rv0 = n_ppu_rv;
        for (int i = 0; i < 16; i++) begin
            drive(1, 12'(i), 0, 0, 12'h000, 8'h00);
            sample();
            check($sformatf("stream_gnt_%0d", i), {63'd0, ppu_gnt}, 64'd1);
            advance();
        end
        drive(0, 12'h000, 0, 0, 12'h000, 8'h00);
        sample();
        advance();
        check("stream_rvalid_count", 64'(n_ppu_rv - rv0), 64'd16);

        // Starvation: CPU write preempts continuous PPU reads after 8 eligible cycles
        rv0 = n_ppu_rv;
        ppu_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            drive(1, 12'h020 + 12'(ppu_cnt), (c == 0), 1, 12'h300, 8'h9E);
            if (c == 0) push_cpu(1, 12'h300, 8'h9E);
            sample();
            check($sformatf("starve_gnt_%0d", c), {63'd0, ppu_gnt}, {63'd0, (c != 9)});
            check($sformatf("starve_wren_%0d", c), {63'd0, vram_wren}, {63'd0, (c == 9)});
            check($sformatf("starve_done_%0d", c), {63'd0, cpu_done}, {63'd0, (c == 10)});
            if (c == 9) begin
                check("starve_addr", {52'd0, vram_addr}, 64'h300);
                check("starve_wdata", {56'd0, vram_wdata}, 64'h9E);
            end
            if (c != 9) ppu_cnt++;
            advance();
        end
        drive(0, 12'h000, 0, 0, 12'h000, 8'h00);
        sample();
        advance();
        check("starve_rvalid_count", 64'(n_ppu_rv - rv0), 64'd14);
        check("starve_mem", {56'd0, mem[12'h300]}, 64'h9E);

        // Interleave: PPU and CPU reads alternate every cycle
        rv0 = n_ppu_rv;
        dn0 = n_cpu_done;
        for (int k = 0; k < 6; k++) begin
            drive(1, 12'h010 + 12'(k), 1, 0, 12'h400 + 12'(k), 8'h00);
            push_cpu(0, 12'h400 + 12'(k), 8'h00);
            sample();
            check($sformatf("ilv_ppu_gnt_%0d", k), {63'd0, ppu_gnt}, 64'd1);
            check($sformatf("ilv_busy_%0d", k), {63'd0, cpu_busy}, 64'd0);
            advance();
            drive(0, 12'h000, 0, 0, 12'h000, 8'h00);
            sample();
            check($sformatf("ilv_cpu_rden_%0d", k), {63'd0, vram_rden}, 64'd1);
            check($sformatf("ilv_cpu_addr_%0d", k), {52'd0, vram_addr}, {52'd0, 12'h400 + 12'(k)});
            advance();
        end
        repeat (3) begin
            sample();
            advance();
        end
        check("ilv_rvalid_count", 64'(n_ppu_rv - rv0), 64'd6);
        check("ilv_done_count", 64'(n_cpu_done - dn0), 64'd6);

        // Reset mid-read: reset lands in the return cycle of a CPU read
        drive(0, 12'h000, 1, 0, 12'h2A5, 8'h00);
        push_cpu(0, 12'h2A5, 8'h00);
        sample();
        advance();
        drive(0, 12'h000, 0, 0, 12'h000, 8'h00);
        sample();
        check("rst_mid_rden", {63'd0, vram_rden}, 64'd1);
        advance();
        reset = 1'b1;
        cpu_q.delete();
        ppu_q.delete();
        #1;
        check("rst_mid_outputs", all_outputs(), 64'd0);
        check("rst_mid_cpu_rdata", {56'd0, cpu_rdata}, 64'd0);
        sample();
        advance();
        reset = 1'b0;
        dn0 = n_cpu_done;
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("rst_after_done_%0d", i), {63'd0, cpu_done}, 64'd0);
            check($sformatf("rst_after_rdata_%0d", i), {56'd0, cpu_rdata}, 64'd0);
            advance();
        end
        check("rst_no_done", 64'(n_cpu_done - dn0), 64'd0);
        check("cpu_queue_drained", 64'(cpu_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
